// File: rtl/st_source_3ch_if.sv
// Stream bundle for st_source_3ch: one addressed input stream and three
// per-channel output streams. "master" is the host/sink side, "slave" is the source block.
interface st_source_3ch_if #(
    parameter int DATA_W = 8
);
    // Handshake: a beat moves on a rising edge where valid && ready; ready
    // never looks at valid, and valid/data hold until the beat is taken.
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_channel;
    logic              in_valid;
    logic              in_ready;

    logic [DATA_W-1:0] out0_data;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out1_data;
    logic              out1_valid;
    logic              out1_ready;
    logic [DATA_W-1:0] out2_data;
    logic              out2_valid;
    logic              out2_ready;

    modport master (
        output in_data, in_channel, in_valid,
        input  in_ready,
        input  out0_data, out0_valid, out1_data, out1_valid, out2_data, out2_valid,
        output out0_ready, out1_ready, out2_ready
    );

    modport slave (
        input  in_data, in_channel, in_valid,
        output in_ready,
        output out0_data, out0_valid, out1_data, out1_valid, out2_data, out2_valid,
        input  out0_ready, out1_ready, out2_ready
    );
endinterface

// File: rtl/st_source_3ch.sv
// Steers an addressed byte stream into three independent FIFOs, each drained
// through its own ready-latency-0 source port. Channel 3 beats are counted and dropped.
module st_source_3ch #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    st_source_3ch_if.slave             st,
    output logic [$clog2(DEPTH):0]     fill0,
    output logic [$clog2(DEPTH):0]     fill1,
    output logic [$clog2(DEPTH):0]     fill2,
    output logic [7:0]                 err_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;

    logic [DATA_W-1:0] mem_q    [3][DEPTH];
    logic [PW-1:0]     wr_ptr_q [3];
    logic [PW-1:0]     rd_ptr_q [3];
    logic [FW-1:0]     fill_q   [3];
    logic [7:0]        err_q;

    logic [3:0] full_ext;
    logic [2:0] out_ready;
    logic [2:0] push;
    logic [2:0] pop;
    logic       accept;
    logic       in_ready_w;

    assign out_ready = {st.out2_ready, st.out1_ready, st.out0_ready};

    always_comb begin
        full_ext = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            full_ext[k] = (fill_q[k] == FW'(DEPTH));
        end
    end

    // Channel 3 is always ready so illegal beats never stall the input.
    assign in_ready_w = (st.in_channel == 2'd3) | ~full_ext[st.in_channel];
    assign accept     = st.in_valid & in_ready_w;
    assign st.in_ready = in_ready_w;

    always_comb begin
        push = 3'b000;
        pop  = 3'b000;
        for (int k = 0; k < 3; k++) begin
            push[k] = accept && (st.in_channel == 2'(k));
            pop[k]  = (fill_q[k] != '0) && out_ready[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                fill_q[k]   <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[k][i] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (push[k]) begin
                    mem_q[k][wr_ptr_q[k]] <= st.in_data;
                    wr_ptr_q[k]           <= wr_ptr_q[k] + PW'(1);
                end
                if (pop[k]) begin
                    rd_ptr_q[k] <= rd_ptr_q[k] + PW'(1);
                end
                // Simultaneous push and pop leaves occupancy unchanged.
                if (push[k] && !pop[k]) begin
                    fill_q[k] <= fill_q[k] + FW'(1);
                end else if (!push[k] && pop[k]) begin
                    fill_q[k] <= fill_q[k] - FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 8'd0;
        end else if (accept && (st.in_channel == 2'd3) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign st.out0_data  = mem_q[0][rd_ptr_q[0]];
    assign st.out1_data  = mem_q[1][rd_ptr_q[1]];
    assign st.out2_data  = mem_q[2][rd_ptr_q[2]];
    assign st.out0_valid = (fill_q[0] != '0);
    assign st.out1_valid = (fill_q[1] != '0);
    assign st.out2_valid = (fill_q[2] != '0);

    assign fill0     = fill_q[0];
    assign fill1     = fill_q[1];
    assign fill2     = fill_q[2];
    assign err_count = err_q;
endmodule

// File: tb/tb_st_source_3ch.sv
// Bench for st_source_3ch: directed scenarios plus a randomized run checked
// against three reference queues.
module tb_st_source_3ch;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] fill0, fill1, fill2;
    logic [7:0] err_count;
    int         checks = 0;
    int         errors = 0;

    st_source_3ch_if #(.DATA_W(DATA_W)) bus ();

    st_source_3ch #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .st        (bus),
        .fill0     (fill0),
        .fill1     (fill1),
        .fill2     (fill2),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Reference model: one expected queue per channel plus an error counter.
    logic [DATA_W-1:0] exp_q0[$];
    logic [DATA_W-1:0] exp_q1[$];
    logic [DATA_W-1:0] exp_q2[$];
    int                exp_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] d,
                         input logic r0, input logic r1, input logic r2);
        bus.in_valid   = v;
        bus.in_channel = ch;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        bus.out2_ready = r2;
    endtask

    function automatic logic [7:0] dut_data(input int k);
        case (k)
            0:       return bus.out0_data;
            1:       return bus.out1_data;
            default: return bus.out2_data;
        endcase
    endfunction

    function automatic logic dut_valid(input int k);
        case (k)
            0:       return bus.out0_valid;
            1:       return bus.out1_valid;
            default: return bus.out2_valid;
        endcase
    endfunction

    function automatic logic [2:0] dut_fill(input int k);
        case (k)
            0:       return fill0;
            1:       return fill1;
            default: return fill2;
        endcase
    endfunction

    function automatic int model_size(input int k);
        case (k)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [7:0] model_head(input int k);
        case (k)
            0:       return exp_q0[0];
            1:       return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    task automatic test_reset();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #2;
        for (int c = 0; c < 4; c++) begin
            bus.in_channel = 2'(c);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready ch=%0d got=%b exp=1", c, bus.in_ready);
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dut_valid(k) !== 1'b0 || dut_fill(k) !== 3'd0 || dut_data(k) !== 8'h00) begin
                errors++;
                $display("FAIL reset_out ch=%0d valid=%b fill=%0d data=%h exp 0/0/00",
                         k, dut_valid(k), dut_fill(k), dut_data(k));
            end
        end
        checks++;
        if (err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_err got=%0d exp=0", err_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_beat();
        drive(1'b1, 2'd1, 8'hA5, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pre rdy=%b v1=%b exp 1/0", bus.in_ready, bus.out1_valid);
        end
        tick();
        drive(1'b0, 2'd1, 8'h00, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (bus.out1_valid !== 1'b1 || bus.out1_data !== 8'hA5 || fill1 !== 3'd1) begin
            errors++;
            $display("FAIL single_visible v=%b d=%h fill=%0d exp 1/a5/1",
                     bus.out1_valid, bus.out1_data, fill1);
        end
        checks++;
        if (bus.out0_valid !== 1'b0 || bus.out2_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_others v0=%b v2=%b exp 0/0", bus.out0_valid, bus.out2_valid);
        end
        tick();
        checks++;
        if (bus.out1_valid !== 1'b0 || fill1 !== 3'd0 || bus.out0_valid !== 1'b0 || bus.out2_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_popped v1=%b fill1=%0d v0=%b v2=%b exp all 0",
                     bus.out1_valid, fill1, bus.out0_valid, bus.out2_valid);
        end
    endtask

    task automatic test_full_backpressure();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 2'd0, 8'(i), 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_fill_rdy beat=%0d got=%b exp=1", i, bus.in_ready);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd0, 8'h55, 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (fill0 !== 3'd4 || bus.in_ready !== 1'b0 || bus.out0_data !== 8'h01 || bus.out0_valid !== 1'b1) begin
                errors++;
                $display("FAIL full_hold fill=%0d rdy=%b d=%h v=%b exp 4/0/01/1",
                         fill0, bus.in_ready, bus.out0_data, bus.out0_valid);
            end
            tick();
        end
        drive(1'b1, 2'd1, 8'h77, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_other_rdy got=%b exp=1", bus.in_ready);
        end
        tick();
        checks++;
        if (fill1 !== 3'd1 || bus.out1_data !== 8'h77) begin
            errors++;
            $display("FAIL full_other_push fill1=%0d d=%h exp 1/77", fill1, bus.out1_data);
        end
        for (int j = 1; j <= 4; j++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1);
            #1;
            checks++;
            if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'(j)) begin
                errors++;
                $display("FAIL full_drain idx=%0d v=%b d=%h exp 1/%h", j, bus.out0_valid, bus.out0_data, 8'(j));
            end
            tick();
        end
        checks++;
        if (bus.out0_valid !== 1'b0 || fill0 !== 3'd0 || fill1 !== 3'd0) begin
            errors++;
            $display("FAIL full_empty v0=%b fill0=%0d fill1=%0d exp 0/0/0", bus.out0_valid, fill0, fill1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'd2, 8'(8'h10 + i), 1'b1, 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'd2, 8'(8'h12 + i), 1'b1, 1'b1, 1'b1);
            #1;
            checks++;
            if (fill2 !== 3'd2 || bus.in_ready !== 1'b1 || bus.out2_data !== 8'(8'h10 + i)) begin
                errors++;
                $display("FAIL b2b cyc=%0d fill=%0d rdy=%b d=%h exp 2/1/%h",
                         i, fill2, bus.in_ready, bus.out2_data, 8'(8'h10 + i));
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'd2, 8'h00, 1'b1, 1'b1, 1'b1);
            #1;
            checks++;
            if (bus.out2_valid !== 1'b1 || bus.out2_data !== 8'(8'h1A + i)) begin
                errors++;
                $display("FAIL b2b_drain idx=%0d v=%b d=%h exp 1/%h", i, bus.out2_valid, bus.out2_data, 8'(8'h1A + i));
            end
            tick();
        end
        checks++;
        if (bus.out2_valid !== 1'b0 || fill2 !== 3'd0) begin
            errors++;
            $display("FAIL b2b_empty v=%b fill=%0d exp 0/0", bus.out2_valid, fill2);
        end
    endtask

    task automatic test_illegal();
        int exp_e;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'd3, 8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b1);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0 || bus.out2_valid !== 1'b0) begin
                errors++;
                $display("FAIL illegal_cyc i=%0d rdy=%b v=%b%b%b exp 1/000",
                         i, bus.in_ready, bus.out0_valid, bus.out1_valid, bus.out2_valid);
            end
            tick();
            exp_e = (i + 1 > 255) ? 255 : i + 1;
            checks++;
            if (err_count !== 8'(exp_e)) begin
                errors++;
                $display("FAIL illegal_err i=%0d got=%0d exp=%0d", i, err_count, exp_e);
            end
        end
        drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd0, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 2'd1, 8'hE9, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (fill0 !== 3'd3 || fill1 !== 3'd1) begin
            errors++;
            $display("FAIL mid_setup fill0=%0d fill1=%0d exp 3/1", fill0, fill1);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0 || fill0 !== 3'd0 ||
            fill1 !== 3'd0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_async v0=%b v1=%b fill0=%0d fill1=%0d err=%0d exp all 0",
                     bus.out0_valid, bus.out1_valid, fill0, fill1, err_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        drive(1'b1, 2'd0, 8'hC3, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.out0_data !== 8'hC3 || fill0 !== 3'd1 || bus.out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_fresh d0=%h fill0=%0d v1=%b exp c3/1/0", bus.out0_data, fill0, bus.out1_valid);
        end
        drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1);
        tick();
        checks++;
        if (fill0 !== 3'd0) begin
            errors++;
            $display("FAIL mid_drain fill0=%0d exp 0", fill0);
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [1:0] ch;
        logic [7:0] d;
        logic [2:0] rdy;
        logic       exp_rdy;
        logic       acc;
        logic [2:0] pops;
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        exp_err = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            v   = ($urandom_range(0, 3) != 0);
            ch  = 2'($urandom_range(0, 3));
            d   = 8'($urandom_range(0, 255));
            rdy = 3'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000);
            drive(v, ch, d, rdy[0], rdy[1], rdy[2]);
            #1;
            exp_rdy = (ch == 2'd3) || (model_size(int'(ch)) < DEPTH);
            checks++;
            if (bus.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_rdy cyc=%0d ch=%0d got=%b exp=%b", cyc, ch, bus.in_ready, exp_rdy);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dut_fill(k) !== 3'(model_size(k)) || dut_valid(k) !== (model_size(k) != 0)) begin
                    errors++;
                    $display("FAIL rand_fill cyc=%0d ch=%0d fill=%0d v=%b exp %0d", cyc, k,
                             dut_fill(k), dut_valid(k), model_size(k));
                end
                if (model_size(k) != 0) begin
                    checks++;
                    if (dut_data(k) !== model_head(k)) begin
                        errors++;
                        $display("FAIL rand_data cyc=%0d ch=%0d got=%h exp=%h", cyc, k, dut_data(k), model_head(k));
                    end
                end
            end
            checks++;
            if (err_count !== 8'(exp_err)) begin
                errors++;
                $display("FAIL rand_err cyc=%0d got=%0d exp=%0d", cyc, err_count, exp_err);
            end
            acc = v && exp_rdy;
            for (int k = 0; k < 3; k++) pops[k] = rdy[k] && (model_size(k) != 0);
            if (pops[0]) void'(exp_q0.pop_front());
            if (pops[1]) void'(exp_q1.pop_front());
            if (pops[2]) void'(exp_q2.pop_front());
            if (acc) begin
                case (ch)
                    2'd0: exp_q0.push_back(d);
                    2'd1: exp_q1.push_back(d);
                    2'd2: exp_q2.push_back(d);
                    default: if (exp_err < 255) exp_err++;
                endcase
            end
            tick();
        end
    endtask

    initial begin
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_single_beat();
        test_full_backpressure();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/st_source_3ch.md
# st_source_3ch

Three-channel Avalon-ST source that feeds the three 8-bit stream sinks of the exam processing core (in0, in1, in2). It accepts a single addressed byte stream (data plus 2-bit channel number) and steers each beat into a per-channel FIFO. Each FIFO drains independently through its own data/valid/ready source port. It sits between a host-side or test byte generator and the core's three sink interfaces, and absorbs per-channel backpressure.

## Interface
Parameters:
- DATA_W, 8, payload width of every stream.
- DEPTH, 4, entries per channel FIFO; power of two, ≥2.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- in_data  in  DATA_W  input beat payload.
- in_channel  in  2  destination channel: 0..2 valid, 3 is illegal.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- outK_data  out  DATA_W  channel K head payload, for K = 0, 1, 2.
- outK_valid  out  1  channel K FIFO non-empty.
- outK_ready  in  1  channel K sink accepts; pop when outK_valid && outK_ready.
- fillK  out  $clog2(DEPTH)+1  channel K occupancy, 0..DEPTH.
- err_count  out  8  count of beats addressed to channel 3; saturates at 255.

## Operation
- Avalon-ST semantics, ready latency 0. A beat transfers only on a cycle where valid and ready are both high at the rising edge.
- in_ready is combinational:
  - in_channel 0..2: !full[in_channel].
  - in_channel 3: 1.
  - in_ready must not depend on in_valid.
- Push: on an accepted beat with in_channel = K ≤ 2, in_data is written at wr_ptr[K], wr_ptr[K] advances, and fillK increments.
- Illegal channel: an accepted beat with in_channel = 3 is discarded. err_count increments unless it is already 255, where it holds.
- Pop: when outK_valid && outK_ready, rd_ptr[K] advances and fillK decrements.
- Simultaneous push and pop on the same channel: both take effect and fillK is unchanged. On a full channel, push is refused because in_ready = 0; the pop still occurs. There is no same-cycle pass-through.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from the fill counter: full = (fill == DEPTH), empty = (fill == 0).
- outK_data = mem[K][rd_ptr[K]]. It is stable while outK_valid is high and outK_ready is low; holding data under backpressure is mandatory.
- outK_valid = (fillK != 0). Once asserted, it stays high until that beat pops.
- Channels are fully independent. A stalled channel never blocks beats addressed to other channels.
- When empty, outK_data is don't-care, but it must not be X in simulation: memory is reset.

## Timing
- Reset (async assert, reset_n = 0):
  - all pointers and fill counters = 0.
  - outK_valid = 0, outK_data = 0, fillK = 0, err_count = 0.
  - memory cleared to 0.
  - in_ready = 1 for every channel value.
- Reset release takes effect on the first rising edge with reset_n = 1. Reset asserted mid-operation discards all buffered beats immediately, without waiting for a clock.
- Latency: a beat accepted at edge t gives outK_valid = 1 and outK_data = payload after edge t, so it is visible in cycle t+1. Earliest pop is at edge t+1.
- Throughput: one input beat per cycle overall. Each output sustains one beat per cycle while its FIFO is non-empty and the sink is ready.
- fillK and err_count are registered and update at the same edge as the transfer.

## Test plan
- Reset and single beat: after reset, check in_ready = 1 and all valids = 0. Push 0xA5 to ch1 at edge t with out1_ready = 1. Required: out1_valid = 1 and out1_data = 0xA5 in cycle t+1, popped at edge t+1, out1_valid = 0 after it, and out0/out2 never valid.
- Full and backpressure: hold out0_ready = 0 and push 0x01..0x04 to ch0. Required: fill0 = 4, in_ready = 0 while in_channel = 0, and out0_data = 0x01 held stable. A 5th beat to ch1 is still accepted. Releasing out0_ready drains 0x01, 0x02, 0x03, 0x04 in order on consecutive cycles.
- Wrap-around and simultaneous events: keep ch2 at fill 2 with out2_ready = 1 while pushing to ch2 every cycle for 10 cycles. Required: fill2 stays 2, order is preserved across pointer wrap, and there are no drops or duplicates.
- Illegal channel: push 300 beats with in_channel = 3. Required: in_ready = 1 throughout, no outK_valid, and err_count saturates at 255.
- Reset mid-operation: with fill0 = 3 and fill1 = 1, assert reset_n = 0 between edges. Required: all valids, fills and err_count drop to 0 immediately. After release, a new beat to ch0 appears first, with no stale data.
- Randomized cross-check: random in_valid, in_channel and outK_ready for 10k cycles against a scoreboard of three queues. Required: exact per-channel order, no loss, and fillK always equals queue size.
